// File: rtl/alu_pkg.sv
// Shared types for the ALU result path.
//   RES_W       : width of the 4:1 result mux output
//   OPSEL_W     : width of the mux select / operation tag
//   res_entry_t : one stored result {data, sel, zero, neg, ovf8}
//   res_flags_t : status flags {zero, neg, ovf8}
//   calc_flags  : derives the status flags from a result word
package alu_pkg;

    localparam int RES_W   = 16;
    localparam int OPSEL_W = 2;

    typedef struct packed {
        logic [RES_W-1:0]   data;
        logic [OPSEL_W-1:0] sel;
        logic               zero;
        logic               neg;
        logic               ovf8;
    } res_entry_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic ovf8;
    } res_flags_t;

    function automatic res_flags_t calc_flags(input logic [RES_W-1:0] data);
        res_flags_t f;
        f.zero = (data == '0);
        f.neg  = data[RES_W-1];
        // Any bit above the low byte means the result does not fit in 8 bits.
        f.ovf8 = |data[RES_W-1:8];
        return f;
    endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Register FIFO holding res_entry_t words.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers and storage)
//   push_i     : write wdata_i at the write pointer (caller guarantees not full)
//   wdata_i    : entry to store
//   pop_i      : advance the read pointer (caller guarantees not empty)
//   rdata_o    : head entry, straight from storage
//   count_o    : number of stored entries, 0..DEPTH
module alu_res_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  res_entry_t               wdata_i,
    input  logic                     pop_i,
    output res_entry_t               rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    res_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    // Pointers are exactly log2(DEPTH) bits, so they wrap without a compare.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/alu_result_stage.sv
// Result capture stage behind the ALU 4:1 result mux.
// Buffers {result, tag, flags} in a small FIFO with valid/ready on both sides
// and counts delivered results.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake
//   in_data, in_sel       : mux result and the select that produced it
//   out_valid/out_ready   : downstream handshake
//   out_data, out_sel     : head result and tag
//   out_zero/neg/ovf8     : head flags, computed when the result was captured
//   res_cnt               : delivered results, modulo 2^CNT_W
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = RES_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [OPSEL_W-1:0] in_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [OPSEL_W-1:0] out_sel,
    output logic               out_zero,
    output logic               out_neg,
    output logic               out_ovf8,
    output logic [CNT_W-1:0]   res_cnt
);

    localparam int             PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    res_entry_t       wr_entry;
    res_entry_t       head;
    res_flags_t       in_flags;
    logic [PTR_W:0]   fifo_cnt;
    logic             push, pop;
    logic             rdy_en_q;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

    // Flags are computed once, on the way in, and stored with the result.
    always_comb begin
        in_flags       = calc_flags(in_data);
        wr_entry.data  = in_data;
        wr_entry.sel   = in_sel;
        wr_entry.zero  = in_flags.zero;
        wr_entry.neg   = in_flags.neg;
        wr_entry.ovf8  = in_flags.ovf8;
    end

    // rdy_en_q keeps in_ready low during reset and until the first edge after
    // release; in_ready depends only on registered state, never on out_ready.
    assign in_ready  = rdy_en_q && (fifo_cnt < DEPTH_CNT);
    assign out_valid = (fifo_cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    alu_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (fifo_cnt)
    );

    always_comb begin
        res_cnt_d = res_cnt_q;
        if (pop) res_cnt_d = res_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q  <= 1'b0;
            res_cnt_q <= '0;
        end else begin
            rdy_en_q  <= 1'b1;
            res_cnt_q <= res_cnt_d;
        end
    end

    assign out_data = head.data;
    assign out_sel  = head.sel;
    assign out_zero = head.zero;
    assign out_neg  = head.neg;
    assign out_ovf8 = head.ovf8;
    assign res_cnt  = res_cnt_q;

endmodule
